// File: rtl/mjpeg_dct_pkg.sv
// Shared constants, cosine table and control-state type for the DCT coefficient engine.
package mjpeg_dct_pkg;

  localparam int unsigned BLK_DIM    = 8;
  localparam int unsigned BLK_PIXELS = 64;
  localparam int unsigned RAD_MOD    = 32;
  localparam int unsigned RAD_W      = $clog2(RAD_MOD);
  localparam int unsigned PIPE_DEPTH = 5;
  localparam int unsigned LUT_IDX_W  = 4;
  localparam int unsigned LUT_MAX    = RAD_MOD / 4;

  // round(100 * cos(k * pi / 16)) for k = 0..8
  localparam int COS_LUT [0:8] = '{100, 98, 92, 83, 71, 56, 38, 20, 0};

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDrain,
    StOut
  } dct_state_e;

  function automatic int cos_mag(input logic [RAD_W-1:0] idx);
    if (idx <= RAD_W'(LUT_MAX)) begin
      return COS_LUT[idx[LUT_IDX_W-1:0]];
    end
    return 0;
  endfunction

endpackage

// File: rtl/mjpeg_dct_coeff_engine_cos.sv
// Combinational quadrant fold of a radian index (units of pi/16) into a signed scaled cosine.
module mjpeg_cos_fold_lut
  import mjpeg_dct_pkg::*;
#(
  parameter int unsigned COS_W = 8
) (
  input  logic [RAD_W-1:0]        rad_i,
  output logic signed [COS_W-1:0] cos_o
);

  localparam logic [RAD_W-1:0] Quarter = RAD_W'(RAD_MOD / 4);
  localparam logic [RAD_W-1:0] Half    = RAD_W'(RAD_MOD / 2);
  localparam logic [RAD_W-1:0] ThreeQ  = RAD_W'(3 * RAD_MOD / 4);

  logic [RAD_W-1:0] idx;
  logic             neg;
  int               mag;

  always_comb begin
    idx = rad_i;
    neg = 1'b0;
    if (rad_i <= Quarter) begin
      idx = rad_i;
    end else if (rad_i <= Half) begin
      idx = Half - rad_i;
      neg = 1'b1;
    end else if (rad_i <= ThreeQ) begin
      idx = rad_i - Half;
      neg = 1'b1;
    end else begin
      // Modular negate gives RAD_MOD - rad_i.
      idx = -rad_i;
    end
  end

  always_comb begin
    mag   = cos_mag(idx);
    cos_o = neg ? -COS_W'(mag) : COS_W'(mag);
  end

endmodule

// File: rtl/mjpeg_dct_coeff_engine.sv
// One raw 2-D DCT coefficient per 8x8 block: level-shifted pixels times the separable
// cosine product, accumulated over 64 samples through a 5-stage valid/ready pipeline.
module mjpeg_dct_coeff_engine
  import mjpeg_dct_pkg::*;
#(
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned COS_W       = 8,
  parameter int unsigned ACC_W       = 32,
  parameter bit          LEVEL_SHIFT = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [2:0]              cmd_u_i,
  input  logic [2:0]              cmd_v_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [PIX_W-1:0]        in_pixel_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [ACC_W-1:0] out_coeff_o,
  output logic [2:0]              out_u_o,
  output logic [2:0]              out_v_o
);

  localparam int unsigned CntW  = $clog2(BLK_PIXELS);
  localparam int unsigned XW    = $clog2(BLK_DIM);
  localparam int unsigned MulW  = XW + 1 + 3;
  localparam int unsigned NVld  = PIPE_DEPTH - 1;
  localparam int unsigned PixSW = PIX_W + 1;
  localparam int unsigned CcW   = 2 * COS_W;
  localparam int unsigned ProdW = PixSW + CcW;

  localparam int                      BiasInt = LEVEL_SHIFT ? (1 << (PIX_W - 1)) : 0;
  localparam logic signed [PixSW-1:0] Bias    = PixSW'(BiasInt);
  localparam logic [CntW-1:0]         LastCnt = CntW'(BLK_PIXELS - 1);

  dct_state_e              state_q, state_d;
  logic [2:0]              u_q, u_d, v_q, v_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  // Stages 1..4 carry a valid bit; stage 5 is the accumulator itself.
  logic [NVld-1:0]         vld_q, vld_d;
  logic [RAD_W-1:0]        s1_ru_q, s1_ru_d, s1_rv_q, s1_rv_d;
  logic signed [PixSW-1:0] s1_pix_q, s1_pix_d;
  logic signed [COS_W-1:0] s2_cu_q, s2_cu_d, s2_cv_q, s2_cv_d;
  logic signed [PixSW-1:0] s2_pix_q, s2_pix_d;
  logic signed [CcW-1:0]   s3_cc_q, s3_cc_d;
  logic signed [PixSW-1:0] s3_pix_q, s3_pix_d;
  logic signed [ProdW-1:0] s4_prod_q, s4_prod_d;

  logic                    in_fire;
  logic [XW-1:0]           pos_x, pos_y;
  logic [MulW-1:0]         ru_full, rv_full;
  logic signed [COS_W-1:0] cu_w, cv_w;

  assign cmd_ready_o = (state_q == StIdle);
  assign in_ready_o  = (state_q == StAccum);
  assign out_valid_o = (state_q == StOut);
  assign out_coeff_o = acc_q;
  assign out_u_o     = u_q;
  assign out_v_o     = v_q;

  assign in_fire = in_valid_i && in_ready_o;
  assign pos_x   = cnt_q[XW-1:0];
  assign pos_y   = cnt_q[CntW-1:XW];
  assign ru_full = MulW'({pos_x, 1'b1}) * MulW'(u_q);
  assign rv_full = MulW'({pos_y, 1'b1}) * MulW'(v_q);

  mjpeg_cos_fold_lut #(
    .COS_W (COS_W)
  ) u_cos_u (
    .rad_i (s1_ru_q),
    .cos_o (cu_w)
  );

  mjpeg_cos_fold_lut #(
    .COS_W (COS_W)
  ) u_cos_v (
    .rad_i (s1_rv_q),
    .cos_o (cv_w)
  );

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          u_d     = cmd_u_i;
          v_d     = cmd_v_i;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (in_valid_i) begin
          if (cnt_q == LastCnt) begin
            state_d = StDrain;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (vld_q == '0) begin
          state_d = StOut;
        end
      end
      StOut: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // The pipeline is always empty in StIdle, so this never collides with the clear above.
    if (vld_q[NVld-1]) begin
      acc_d = acc_q + ACC_W'(s4_prod_q);
    end
  end

  always_comb begin
    vld_d     = {vld_q[NVld-2:0], in_fire};
    s1_ru_d   = ru_full[RAD_W-1:0];
    s1_rv_d   = rv_full[RAD_W-1:0];
    s1_pix_d  = $signed({1'b0, in_pixel_i}) - Bias;
    s2_cu_d   = cu_w;
    s2_cv_d   = cv_w;
    s2_pix_d  = s1_pix_q;
    s3_cc_d   = s2_cu_q * s2_cv_q;
    s3_pix_d  = s2_pix_q;
    s4_prod_d = s3_pix_q * s3_cc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      u_q       <= '0;
      v_q       <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      vld_q     <= '0;
      s1_ru_q   <= '0;
      s1_rv_q   <= '0;
      s1_pix_q  <= '0;
      s2_cu_q   <= '0;
      s2_cv_q   <= '0;
      s2_pix_q  <= '0;
      s3_cc_q   <= '0;
      s3_pix_q  <= '0;
      s4_prod_q <= '0;
    end else begin
      state_q   <= state_d;
      u_q       <= u_d;
      v_q       <= v_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      vld_q     <= vld_d;
      s1_ru_q   <= s1_ru_d;
      s1_rv_q   <= s1_rv_d;
      s1_pix_q  <= s1_pix_d;
      s2_cu_q   <= s2_cu_d;
      s2_cv_q   <= s2_cv_d;
      s2_pix_q  <= s2_pix_d;
      s3_cc_q   <= s3_cc_d;
      s3_pix_q  <= s3_pix_d;
      s4_prod_q <= s4_prod_d;
    end
  end

endmodule

// File: tb/tb_mjpeg_dct_coeff_engine.sv
// Directed bench for the DCT coefficient engine with an independent floating-point cosine model.
module tb_mjpeg_dct_coeff_engine;

  localparam real PI = 3.14159265358979;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [2:0]         cmd_u = '0;
  logic [2:0]         cmd_v = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [7:0]         in_pixel = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [31:0] out_coeff;
  logic [2:0]         out_u;
  logic [2:0]         out_v;

  int         n_checks = 0;
  int         n_fail = 0;
  int         n_timeouts = 0;
  logic [7:0] blk [64];

  mjpeg_dct_coeff_engine #(
    .PIX_W       (8),
    .COS_W       (8),
    .ACC_W       (32),
    .LEVEL_SHIFT (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_u_i     (cmd_u),
    .cmd_v_i     (cmd_v),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_pixel_i  (in_pixel),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_coeff_o (out_coeff),
    .out_u_o     (out_u),
    .out_v_o     (out_v)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cosv(input int r);
    real c;
    c = 100.0 * $cos(real'(r) * PI / 16.0);
    if (c >= 0.0) return $rtoi(c + 0.5);
    return -$rtoi(0.5 - c);
  endfunction

  function automatic longint model(input int u, input int v);
    longint s = 0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        s += longint'(int'(blk[y*8+x]) - 128) * longint'(cosv((2*x+1)*u))
             * longint'(cosv((2*y+1)*v));
      end
    end
    return s;
  endfunction

  task automatic fill(input int val);
    for (int i = 0; i < 64; i++) blk[i] = 8'(val);
  endtask

  task automatic start_cmd(input string tag, input int u, input int v);
    int n = 0;
    while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
    check({tag, ":cmd_ready"}, longint'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_u = 3'(u);
    cmd_v = 3'(v);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_pixels(input int count, input int gap_max);
    int n;
    for (int i = 0; i < count; i++) begin
      if (gap_max > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_pixel = blk[i];
      n = 0;
      while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
      if (n >= 200) n_timeouts++;
      @(posedge clk); #1;
    end
  endtask

  // in_valid stays high after the last pixel so a 65th sample would be taken if in_ready lingered.
  task automatic finish_block(input string tag, input int u, input int v, input int stall,
                              input longint exp);
    int n = 0;
    check({tag, ":no_65th"}, longint'(in_ready), 0);
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    in_valid = 1'b0;
    cmd_valid = 1'b0;
    check({tag, ":latency"}, n, 5);
    check({tag, ":in_timeouts"}, n_timeouts, 0);
    check({tag, ":coeff"}, longint'(out_coeff), exp);
    check({tag, ":u"}, longint'(out_u), u);
    check({tag, ":v"}, longint'(out_v), v);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, ":stall_valid"}, longint'(out_valid), 1);
      check({tag, ":stall_coeff"}, longint'(out_coeff), exp);
      check({tag, ":stall_busy"}, longint'({cmd_ready, in_ready}), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ":out_done"}, longint'(out_valid), 0);
    check({tag, ":idle_ready"}, longint'(cmd_ready), 1);
  endtask

  task automatic run_block(input string tag, input int u, input int v, input int gap_max,
                           input int stall, input longint exp);
    start_cmd(tag, u, v);
    send_pixels(64, gap_max);
    finish_block(tag, u, v, stall, exp);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst:cmd_ready", longint'(cmd_ready), 1);
    check("rst:in_ready", longint'(in_ready), 0);
    check("rst:out_valid", longint'(out_valid), 0);
    check("rst:coeff", longint'(out_coeff), 0);
    check("rst:uv", longint'({out_u, out_v}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    fill(255);
    run_block("dc_255", 0, 0, 0, 0, 64'd81280000);
    fill(128);
    run_block("dc_128", 0, 0, 0, 0, 64'd0);
    fill(200);
    run_block("u1_flat", 1, 0, 0, 0, 64'd0);
    fill(128);
    for (int y = 0; y < 8; y++) blk[y*8] = 8'd255;
    run_block("u1_edge", 1, 0, 0, 0, 64'd9956800);

    for (int i = 0; i < 64; i++) blk[i] = 8'($urandom_range(255, 0));
    run_block("gaps_stall", 3, 5, 3, 10, model(3, 5));

    for (int u = 0; u < 8; u++) begin
      for (int v = 0; v < 8; v++) begin
        run_block($sformatf("sweep_u%0d_v%0d", u, v), u, v, 0, 0, model(u, v));
      end
    end

    // Abort a block after pixel 30, then run a clean one with a command held high while busy.
    fill(60);
    start_cmd("abort", 6, 7);
    send_pixels(31, 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort:cmd_ready", longint'(cmd_ready), 1);
    check("abort:in_ready", longint'(in_ready), 0);
    check("abort:coeff", longint'(out_coeff), 0);
    check("abort:uv", longint'({out_u, out_v}), 0);
    fill(129);
    start_cmd("after_rst", 0, 0);
    cmd_valid = 1'b1;
    cmd_u = 3'd5;
    cmd_v = 3'd3;
    send_pixels(64, 0);
    finish_block("after_rst", 0, 0, 2, 64'd640000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mjpeg_dct_coeff_engine.md
Name: mjpeg_dct_coeff_engine

Overview:
- Computes one raw 2-D DCT coefficient per 8x8 block: sum over x,y of (pixel - 128) * cos((2x+1)u*pi/16) * cos((2y+1)v*pi/16).
- Integer cosines are scaled by 100.
- Parametrised, handshaked successor to the per-sample cosine-product pipeline. It adds the level shift, pixel multiply, 64-sample accumulation, internal index generation and valid/ready flow control.
- Sits between the block buffer (pixel source) and the quantiser, which applies the C(u)C(v)/4 normalisation.

Parameters:
- PIX_W, 8, unsigned pixel width.
- COS_W, 8, signed cosine width; LUT magnitudes 100,98,92,83,71,56,38,20,0.
- ACC_W, 32, signed accumulator and output width; must be >= PIX_W+2*COS_W+7.
- LEVEL_SHIFT, 1, 1 subtracts 2^(PIX_W-1) from each pixel; 0 treats pixel as unsigned zero-extended.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- cmd_valid  in  1  block command valid
- cmd_ready  out  1  high only in IDLE
- cmd_u  in  3  horizontal frequency (column)
- cmd_v  in  3  vertical frequency (row)
- in_valid  in  1  pixel valid
- in_ready  out  1  high only in ACCUM
- in_pixel  in  PIX_W  pixel, raster order (x fastest, then y)
- out_valid  out  1  coefficient valid
- out_ready  in  1  consumer ready
- out_coeff  out  ACC_W  signed raw coefficient sum
- out_u  out  3  u of out_coeff
- out_v  out  3  v of out_coeff

Behaviour:
- Reset: rst_n is synchronous, active-low, on clk. It clears state to IDLE, all pipeline valids and data, the accumulator and the counters. Reset values: cmd_ready=1, in_ready=0, out_valid=0, out_coeff=0, out_u=0, out_v=0.
- Reset mid-block aborts the block. There is no partial output, and the next command starts clean.
- States:
  - IDLE: on cmd_valid&&cmd_ready, latch u,v, clear acc and pixel counter, go to ACCUM.
  - ACCUM: each in_valid&&in_ready accepts one pixel; counter 0..63 gives x=cnt[2:0], y=cnt[5:3]. After pixel 63 is accepted, go to DRAIN.
  - DRAIN: wait until the pipeline is empty, then go to OUT.
  - OUT: out_valid=1 with out_coeff, out_u, out_v stable. On out_ready, go to IDLE.
- Pipeline: 5 stages, a valid bit per stage, one pixel per cycle, bubbles allowed.
  - S1: ru=((2x+1)*u) mod 32, rv=((2y+1)*v) mod 32, shifted pixel.
  - S2: fold each r into an index 0..8 plus a negate flag:
    - r<=8: idx=r, +
    - 9..16: idx=16-r, -
    - 17..24: idx=r-16, -
    - 25..31: idx=32-r, +
  - S3: LUT lookup, apply sign.
  - S4: cu*cv, signed 2*COS_W bits.
  - S5: acc += pshift*(cu*cv), full-precision sign-extended.
- Latency: out_valid rises exactly 5 cycles after the edge that accepted pixel 63, provided no earlier pixel is still in flight.
- cmd_valid is ignored when not in IDLE. in_pixel is ignored when in_ready=0.
- The counter never wraps inside a block. A 65th pixel is not accepted because in_ready drops the cycle after pixel 63.
- No overflow handling is needed: ACC_W sizing guarantees none at the defaults, with a maximum |sum| of 128*100*100*64 = 81,920,000.

Decomposition:
- Package mjpeg_dct_pkg holds:
  - COS_LUT constant array [0:8].
  - BLK_DIM=8, BLK_PIXELS=64, RAD_MOD=32.
  - State enum {IDLE, ACCUM, DRAIN, OUT}.
  - PIPE_DEPTH=5.
- Sub-module mjpeg_cos_fold_lut is combinational: 5-bit radian in, signed COS_W cosine out (fold + lookup + sign). It is instantiated twice, for u and v.

Test Plan:
- u=0,v=0, all pixels 255, LEVEL_SHIFT=1 -> out_coeff=127*100*100*64=81,280,000, out_u=0, out_v=0.
- u=0,v=0, all pixels 128 -> out_coeff=0. Also u=1,v=0 with pixels 200 -> 0, since the folded cosine sum over x is 98+83+56+20-20-56-83-98=0.
- u=1,v=0, pixel=255 at x=0 and 128 elsewhere -> out_coeff=127*98*100*8=9,956,800. out_valid rises 5 cycles after the last accept when in_valid is held high.
- Random in_valid gaps plus out_ready low for 10 cycles -> coefficient matches the golden model. out_coeff stays stable while stalled. cmd_ready and in_ready stay 0 until the output handshake completes.
- Sweep all 64 (u,v) pairs on a random block -> all match the golden model, including the fold boundaries r=8,16,24 (idx 8 gives 0) and u=7,v=7.
- rst_n low for 1 cycle after pixel 30, then a new command with 64 pixels of 129 at u=v=0 -> out_coeff=640,000 with no residue from the aborted block. cmd_valid while busy -> ignored.
